maxnet_controller: RTL and testbench



---
 rtl/maxnet_controller.sv | 125 ++++++++++++
 tb/tb_maxnet_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequencer for a 4-neuron Maxnet: loads activations, time-shares one FP update unit across
// the neurons, commits each iteration and reports the winner, timeout or all-zero outcome.
module maxnet_controller #(
  parameter int FP_LAT   = 2,
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] nonzero,
  output logic       ld_x,
  output logic       fp_go,
  output logic [1:0] sel,
  output logic       wr_en,
  output logic       commit,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       timeout,
  output logic       no_winner
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_COMMIT  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam int          CW       = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(FP_LAT - 1);
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  logic [2:0]        state;
  logic [ITER_W-1:0] iter;
  logic [CW-1:0]     wcnt;
  logic [2:0]        pop;
  logic [1:0]        low_idx;

  assign pop = {2'b00, nonzero[0]} + {2'b00, nonzero[1]} +
               {2'b00, nonzero[2]} + {2'b00, nonzero[3]};

  // Lowest set index; doubles as the single-survivor index when only one bit is set.
  always_comb begin
    low_idx = 2'd0;
    casez (nonzero)
      4'b???1: low_idx = 2'd0;
      4'b??10: low_idx = 2'd1;
      4'b?100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      iter      <= '0;
      wcnt      <= '0;
      sel       <= 2'd0;
      winner    <= 2'd0;
      timeout   <= 1'b0;
      no_winner <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            iter      <= '0;
            sel       <= 2'd0;
            winner    <= 2'd0;
            timeout   <= 1'b0;
            no_winner <= 1'b0;
          end
        end
        S_LOAD: state <= S_CHECK;
        S_CHECK: begin
          if (pop <= 3'd1) begin
            state     <= S_DONE;
            winner    <= low_idx;
            no_winner <= (nonzero == 4'b0000);
          end else if (iter == ITER_LIMIT) begin
            state   <= S_DONE;
            winner  <= low_idx;
            timeout <= 1'b1;
          end else begin
            iter  <= iter + 1'b1;
            sel   <= 2'd0;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == WAIT_LAST) state <= S_WRITE;
          else                   wcnt  <= wcnt + 1'b1;
        end
        S_WRITE: begin
          if (sel == 2'd3) begin
            state <= S_COMMIT;
          end else begin
            sel   <= sel + 1'b1;
            state <= S_COMPUTE;
          end
        end
        S_COMMIT: state <= S_CHECK;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign ld_x   = (state == S_LOAD);
  assign fp_go  = (state == S_COMPUTE);
  assign wr_en  = (state == S_WRITE);
  assign commit = (state == S_COMMIT);
  assign done   = (state == S_DONE);
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: expected strobe events are queued per run and
// matched against the strobes the controller produces.
module tb_maxnet_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] nonzero;
  logic       ld_x, fp_go, wr_en, commit, busy, done, timeout, no_winner;
  logic [1:0] sel, winner;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         kind;  // 0 ld_x, 1 fp_go, 2 wr_en, 3 commit, 4 done
    int         cyc;
    logic [1:0] sel;
    logic [1:0] win;
    logic       to;
    logic       nw;
  } ev_t;

  ev_t exp_q[$];

  maxnet_controller #(.FP_LAT(2), .MAX_ITER(15), .ITER_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .nonzero(nonzero),
    .ld_x(ld_x), .fp_go(fp_go), .sel(sel), .wr_en(wr_en), .commit(commit),
    .busy(busy), .done(done), .winner(winner), .timeout(timeout), .no_winner(no_winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int kind, input int cyc, input logic [1:0] s,
                      input logic [1:0] w, input logic t, input logic n);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.sel = s; e.win = w; e.to = t; e.nw = n;
    exp_q.push_back(e);
  endtask

  // One full iteration whose first COMPUTE falls in cycle c (FP_LAT = 2).
  task automatic push_iter(input int c);
    for (int k = 0; k < 4; k++) begin
      push(1, c + 4 * k,     2'(k), 2'd0, 1'b0, 1'b0);
      push(2, c + 4 * k + 3, 2'(k), 2'd0, 1'b0, 1'b0);
    end
    push(3, c + 16, 2'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic run(input string name, input logic [3:0] nz0, input logic [3:0] nz1,
                     input int max_cyc, input int start_at, input int rst_at);
    int  rel;
    int  kind;
    bit  fin;
    ev_t e;
    nonzero = nz0;
    @(negedge clk);
    start = 1'b1;
    rel   = 0;
    fin   = 1'b0;
    while (!fin && rel < max_cyc) begin
      @(negedge clk);
      rel++;
      start = (rel == start_at);
      if (ld_x | fp_go | wr_en | commit | done) begin
        kind = done ? 4 : commit ? 3 : wr_en ? 2 : fp_go ? 1 : 0;
        if (exp_q.size() == 0) begin
          check($sformatf("%s_unexpected_event@%0d", name, rel), kind, 32'hFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_kind@%0d", name, rel), kind, e.kind);
          check($sformatf("%s_cycle_kind%0d", name, kind), rel, e.cyc);
          if (kind == 1 || kind == 2)
            check($sformatf("%s_sel@%0d", name, rel), sel, e.sel);
          if (kind == 4) begin
            check($sformatf("%s_winner", name), winner, e.win);
            check($sformatf("%s_timeout", name), timeout, e.to);
            check($sformatf("%s_no_winner", name), no_winner, e.nw);
            fin = 1'b1;
          end
          if (kind == 3) nonzero = nz1;
        end
      end
      if (rel == 1) check($sformatf("%s_busy_in_load", name), busy, 1);
      if (rel == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("%s_outputs_after_rst", name),
              {ld_x, fp_go, sel, wr_en, commit, busy, done, winner, timeout, no_winner}, 0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 25; i++) begin
          @(negedge clk);
          check($sformatf("%s_quiet_after_rst", name),
                {ld_x, fp_go, wr_en, commit, done, busy}, 0);
        end
        fin = 1'b1;
      end
    end
    start = 1'b0;
    check($sformatf("%s_finished_in_budget", name), fin, 1);
    check($sformatf("%s_events_left", name), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    nonzero = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs",
            {ld_x, fp_go, sel, wr_en, commit, busy, done, winner, timeout, no_winner}, 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, ld_x}, 0);

    // Already converged: only neuron 2 alive.
    push(0, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    push(4, 3, 2'd0, 2'd2, 1'b0, 1'b0);
    run("preconv", 4'b0100, 4'b0100, 40, -1, -1);

    // One iteration, neuron 3 survives.
    push(0, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    push_iter(3);
    push(4, 21, 2'd0, 2'd3, 1'b0, 1'b0);
    run("one_iter", 4'b1111, 4'b1000, 60, -1, -1);

    // Same run with a stray start pulse in WAIT.
    push(0, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    push_iter(3);
    push(4, 21, 2'd0, 2'd3, 1'b0, 1'b0);
    run("start_in_wait", 4'b1111, 4'b1000, 60, 4, -1);

    // Two tied maxima never converge.
    push(0, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) push_iter(3 + 18 * i);
    push(4, 273, 2'd0, 2'd0, 1'b1, 1'b0);
    run("timeout", 4'b0011, 4'b0011, 400, -1, -1);

    // All activations zero.
    push(0, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    push(4, 3, 2'd0, 2'd0, 1'b0, 1'b1);
    run("all_zero", 4'b0000, 4'b0000, 40, -1, -1);

    // Reset lands in the second WAIT (cycle 8).
    push(0, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    push_iter(3);
    run("rst_mid_wait", 4'b1111, 4'b1000, 60, -1, 8);

    // Fresh run after reset repeats the one-iteration timing.
    push(0, 1, 2'd0, 2'd0, 1'b0, 1'b0);
    push_iter(3);
    push(4, 21, 2'd0, 2'd3, 1'b0, 1'b0);
    run("after_rst", 4'b1111, 4'b1000, 60, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
